// File: rtl/apb_timer_nbit_pkg.sv
// Shared register map, control/status bit positions and address decode for apb_timer_nbit.
package apb_timer_nbit_pkg;

  localparam logic [4:0] TCNT_OFS = 5'h00;
  localparam logic [4:0] TDR_OFS  = 5'h04;
  localparam logic [4:0] TCMP_OFS = 5'h08;
  localparam logic [4:0] TCR_OFS  = 5'h0C;
  localparam logic [4:0] TSR_OFS  = 5'h10;
  localparam logic [4:0] TIER_OFS = 5'h14;

  localparam int TCR_EN      = 0;
  localparam int TCR_DIR     = 1;
  localparam int TCR_ARLD    = 2;
  localparam int TCR_LOAD    = 3;
  localparam int TCR_CKS_LSB = 4;
  localparam int TCR_CKS_MSB = 6;

  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;
  localparam int TSR_CMF = 2;

  localparam int CKS_W  = TCR_CKS_MSB - TCR_CKS_LSB + 1;
  localparam int FLAG_W = 3;

  typedef enum logic [2:0] {
    SEL_TCNT,
    SEL_TDR,
    SEL_TCMP,
    SEL_TCR,
    SEL_TSR,
    SEL_TIER,
    SEL_NONE
  } reg_sel_e;

  function automatic reg_sel_e addr_to_sel(input logic [4:0] ofs);
    case (ofs)
      TCNT_OFS: return SEL_TCNT;
      TDR_OFS:  return SEL_TDR;
      TCMP_OFS: return SEL_TCMP;
      TCR_OFS:  return SEL_TCR;
      TSR_OFS:  return SEL_TSR;
      TIER_OFS: return SEL_TIER;
      default:  return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/apb_timer_nbit_prescaler.sv
// Free-running pclk prescaler: counts while enabled, held at zero otherwise.
// o_tick is combinational and fires once every 2^cks enabled cycles.
module apb_timer_nbit_prescaler
  import apb_timer_nbit_pkg::*;
#(
  parameter int PSC_WIDTH = 7
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [CKS_W-1:0] i_cks,
  output logic             o_tick
);

  logic [PSC_WIDTH-1:0] r_psc;
  logic [PSC_WIDTH-1:0] w_mask;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_psc <= '0;
    end else if (!i_en) begin
      r_psc <= '0;
    end else begin
      r_psc <= r_psc + 1'b1;
    end
  end

  // Mask covers the low cks bits; an empty mask (cks=0) ticks every cycle.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < PSC_WIDTH; i++) begin
      w_mask[i] = (i < int'(i_cks));
    end
    o_tick = i_en && ((r_psc & w_mask) == w_mask);
  end

endmodule

// File: rtl/apb_timer_nbit.sv
// APB3 timer/counter with prescaler, auto-reload, compare match and maskable irq.
// Zero wait-state slave; register writes commit at the end of the access cycle.
module apb_timer_nbit
  import apb_timer_nbit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16,
  parameter int PSC_WIDTH  = 7
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic                  tmr_ovf,
  output logic                  tmr_udf,
  output logic                  irq
);

  logic [CNT_WIDTH-1:0]  r_tcnt;
  logic [CNT_WIDTH-1:0]  r_tdr;
  logic [CNT_WIDTH-1:0]  r_tcmp;
  logic                  r_en;
  logic                  r_dir;
  logic                  r_arld;
  logic [CKS_W-1:0]      r_cks;
  logic [FLAG_W-1:0]     r_tsr;
  logic [FLAG_W-1:0]     r_tier;
  logic                  r_irq;

  logic                  w_access;
  logic                  w_addr_err;
  logic                  w_wr;
  logic                  w_rd;
  reg_sel_e              w_sel;
  logic [CNT_WIDTH-1:0]  w_wdata_cnt;
  logic [CKS_W-1:0]      w_cks_wr;
  logic [CKS_W-1:0]      w_cks_clamped;
  logic                  w_wr_tcnt;
  logic                  w_load;
  logic                  w_tick;
  logic [CNT_WIDTH-1:0]  w_tcnt_nxt;
  logic [FLAG_W-1:0]     w_set;
  logic [FLAG_W-1:0]     w_tsr_clr;
  logic [FLAG_W-1:0]     w_tsr_nxt;
  logic [FLAG_W-1:0]     w_tier_nxt;
  logic [DATA_WIDTH-1:0] w_rd_val;
  logic                  w_unused_wdata;

  assign w_access    = psel & penable;
  assign w_addr_err  = (paddr[1:0] != 2'b00) || (paddr > ADDR_WIDTH'(TIER_OFS));
  assign w_sel       = w_addr_err ? SEL_NONE : addr_to_sel(paddr[4:0]);
  assign w_wr        = w_access & pwrite & ~w_addr_err;
  assign w_rd        = w_access & ~pwrite & ~w_addr_err;
  assign w_wdata_cnt = pwdata[CNT_WIDTH-1:0];
  assign w_unused_wdata = ^pwdata;

  assign w_cks_wr      = pwdata[TCR_CKS_MSB:TCR_CKS_LSB];
  assign w_cks_clamped = (int'(w_cks_wr) > PSC_WIDTH) ? CKS_W'(PSC_WIDTH) : w_cks_wr;

  assign w_wr_tcnt = w_wr && (w_sel == SEL_TCNT);
  assign w_load    = w_wr && (w_sel == SEL_TCR) && pwdata[TCR_LOAD];

  apb_timer_nbit_prescaler #(
    .PSC_WIDTH (PSC_WIDTH)
  ) u_prescaler (
    .i_clk  (pclk),
    .i_rst  (preset),
    .i_en   (r_en),
    .i_cks  (r_cks),
    .o_tick (w_tick)
  );

  // A software write or load wins outright: the tick's count and flag effects are dropped.
  always_comb begin
    w_tcnt_nxt = r_tcnt;
    w_set      = '0;
    if (w_wr_tcnt) begin
      w_tcnt_nxt = w_wdata_cnt;
    end else if (w_load) begin
      w_tcnt_nxt = r_tdr;
    end else if (w_tick) begin
      if (r_tcnt == r_tcmp) begin
        w_set[TSR_CMF] = 1'b1;
      end
      if (!r_dir) begin
        if (r_tcnt == '1) begin
          w_tcnt_nxt     = r_arld ? r_tdr : '0;
          w_set[TSR_OVF] = 1'b1;
        end else begin
          w_tcnt_nxt = r_tcnt + 1'b1;
        end
      end else begin
        if (r_tcnt == '0) begin
          w_tcnt_nxt     = r_arld ? r_tdr : '1;
          w_set[TSR_UDF] = 1'b1;
        end else begin
          w_tcnt_nxt = r_tcnt - 1'b1;
        end
      end
    end
  end

  assign w_tsr_clr  = (w_wr && (w_sel == SEL_TSR)) ? pwdata[FLAG_W-1:0] : '0;
  assign w_tsr_nxt  = (r_tsr & ~w_tsr_clr) | w_set;
  assign w_tier_nxt = (w_wr && (w_sel == SEL_TIER)) ? pwdata[FLAG_W-1:0] : r_tier;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_tcnt <= '0;
      r_tdr  <= '0;
      r_tcmp <= '0;
      r_en   <= 1'b0;
      r_dir  <= 1'b0;
      r_arld <= 1'b0;
      r_cks  <= '0;
      r_tsr  <= '0;
      r_tier <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_tcnt <= w_tcnt_nxt;
      r_tsr  <= w_tsr_nxt;
      r_tier <= w_tier_nxt;
      // irq tracks the next TSR/TIER so it lands in the same cycle as the flag.
      r_irq  <= |(w_tsr_nxt & w_tier_nxt);
      if (w_wr && (w_sel == SEL_TDR)) begin
        r_tdr <= w_wdata_cnt;
      end
      if (w_wr && (w_sel == SEL_TCMP)) begin
        r_tcmp <= w_wdata_cnt;
      end
      if (w_wr && (w_sel == SEL_TCR)) begin
        r_en   <= pwdata[TCR_EN];
        r_dir  <= pwdata[TCR_DIR];
        r_arld <= pwdata[TCR_ARLD];
        r_cks  <= w_cks_clamped;
      end
    end
  end

  always_comb begin
    w_rd_val = '0;
    case (w_sel)
      SEL_TCNT: w_rd_val[CNT_WIDTH-1:0] = r_tcnt;
      SEL_TDR:  w_rd_val[CNT_WIDTH-1:0] = r_tdr;
      SEL_TCMP: w_rd_val[CNT_WIDTH-1:0] = r_tcmp;
      SEL_TCR: begin
        w_rd_val[TCR_EN]                  = r_en;
        w_rd_val[TCR_DIR]                 = r_dir;
        w_rd_val[TCR_ARLD]                = r_arld;
        w_rd_val[TCR_CKS_MSB:TCR_CKS_LSB] = r_cks;
      end
      SEL_TSR:  w_rd_val[FLAG_W-1:0] = r_tsr;
      SEL_TIER: w_rd_val[FLAG_W-1:0] = r_tier;
      default:  w_rd_val = '0;
    endcase
  end

  assign prdata  = w_rd ? w_rd_val : '0;
  assign pready  = 1'b1;
  assign pslverr = w_access & w_addr_err;
  assign tmr_ovf = r_tsr[TSR_OVF];
  assign tmr_udf = r_tsr[TSR_UDF];
  assign irq     = r_irq;

endmodule

// File: tb/tb_apb_timer_nbit.sv
// Bench for apb_timer_nbit: directed scenarios plus random APB traffic against a
// cycle-level behavioural model of the timer.
module tb_apb_timer_nbit;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel, penable, pwrite;
  logic [4:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr, tmr_ovf, tmr_udf, irq;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] cap_prdata;
  logic        cap_err;

  // behavioural model state
  int       m_tcnt, m_tdr, m_tcmp, m_cks, m_en_cycles;
  bit       m_en, m_dir, m_arld;
  bit [2:0] m_tsr, m_tier;

  always #5 pclk = ~pclk;

  apb_timer_nbit #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5),
    .CNT_WIDTH  (16),
    .PSC_WIDTH  (7)
  ) dut (
    .pclk    (pclk),
    .preset  (preset),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .tmr_ovf (tmr_ovf),
    .tmr_udf (tmr_udf),
    .irq     (irq)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_tcnt = 0; m_tdr = 0; m_tcmp = 0; m_cks = 0; m_en_cycles = 0;
    m_en = 0; m_dir = 0; m_arld = 0; m_tsr = 0; m_tier = 0;
  endfunction

  function automatic bit bad_addr(input logic [4:0] a);
    return (a % 4 != 0) || (a > 5'h14);
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'h00:   return m_tcnt;
      5'h04:   return m_tdr;
      5'h08:   return m_tcmp;
      5'h0C:   return (m_cks << 4) | (m_arld << 2) | (m_dir << 1) | m_en;
      5'h10:   return {29'd0, m_tsr};
      5'h14:   return {29'd0, m_tier};
      default: return 0;
    endcase
  endfunction

  // One clock edge of the reference: the timer advances when the number of enabled
  // cycles so far is one short of a multiple of the division ratio.
  function automatic void model_step(input bit wr, input logic [4:0] a, input logic [31:0] d);
    int       period = 1 << m_cks;
    bit       tick   = m_en && ((m_en_cycles % period) == period - 1);
    int       ntcnt  = m_tcnt;
    bit [2:0] set    = 0;
    bit [2:0] clr    = 0;
    if (wr && a == 5'h00) ntcnt = d[15:0];
    else if (wr && a == 5'h0C && d[3]) ntcnt = m_tdr;
    else if (tick) begin
      if (m_tcnt == m_tcmp) set[2] = 1;
      if (!m_dir) begin
        if (m_tcnt == 65535) begin ntcnt = m_arld ? m_tdr : 0; set[0] = 1; end
        else ntcnt = m_tcnt + 1;
      end else begin
        if (m_tcnt == 0) begin ntcnt = m_arld ? m_tdr : 65535; set[1] = 1; end
        else ntcnt = m_tcnt - 1;
      end
    end
    m_en_cycles = m_en ? m_en_cycles + 1 : 0;
    if (wr && a == 5'h10) clr = d[2:0];
    m_tsr = (m_tsr & ~clr) | set;
    if (wr && a == 5'h04) m_tdr = d[15:0];
    if (wr && a == 5'h08) m_tcmp = d[15:0];
    if (wr && a == 5'h0C) begin
      m_en = d[0]; m_dir = d[1]; m_arld = d[2];
      m_cks = (d[6:4] > 7) ? 7 : int'(d[6:4]);
    end
    if (wr && a == 5'h14) m_tier = d[2:0];
    m_tcnt = ntcnt;
  endfunction

  // Drive one cycle (entered just after a rising edge), check outputs mid-cycle.
  task automatic cyc(input bit s, input bit e, input bit w, input logic [4:0] a, input logic [31:0] d);
    bit acc;
    bit err;
    psel = s; penable = e; pwrite = w; paddr = a; pwdata = d;
    @(negedge pclk);
    acc = s && e;
    err = acc && bad_addr(a);
    cap_prdata = prdata;
    cap_err    = pslverr;
    chk("pready", pready, 1);
    chk("pslverr", pslverr, err);
    chk("prdata", prdata, (acc && !w && !err) ? model_read(a) : 0);
    chk("tmr_ovf", tmr_ovf, m_tsr[0]);
    chk("tmr_udf", tmr_udf, m_tsr[1]);
    chk("irq", irq, |(m_tsr & m_tier));
    model_step(acc && w && !err, a, d);
    @(posedge pclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 5'h00, 0);
  endtask

  task automatic apb(input bit w, input logic [4:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err);
    cyc(1, 0, w, a, d);
    cyc(1, 1, w, a, d);
    rd  = cap_prdata;
    err = cap_err;
    psel = 0; penable = 0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic        err;
    apb(1, a, d, rd, err);
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic        err;
    apb(0, a, 0, rd, err);
    chk(tag, rd, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    logic [4:0]  a;
    logic [31:0] d;
    int          op;

    psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    preset = 1;
    model_reset();
    #1;
    chk("rst_irq", irq, 0);
    chk("rst_ovf", tmr_ovf, 0);
    @(posedge pclk); #1;
    preset = 0;

    rd_chk("rst_tcnt", 5'h00, 0);
    rd_chk("rst_tcr", 5'h0C, 0);
    rd_chk("rst_tsr", 5'h10, 0);

    // up wrap without auto-reload
    wr(5'h00, 32'hFFFE);
    wr(5'h0C, 32'h1);
    wr(5'h0C, 32'h0);
    rd_chk("wrap_tcnt", 5'h00, 32'h0000);
    chk("wrap_ovf", tmr_ovf, 1);
    chk("wrap_irq_masked", irq, 0);
    wr(5'h14, 32'h1);
    chk("wrap_irq_enabled", irq, 1);

    // down count with auto-reload, cks=2
    wr(5'h10, 32'h7);
    wr(5'h14, 32'h0);
    wr(5'h04, 32'h5);
    wr(5'h00, 32'h0);
    wr(5'h0C, 32'h27);
    idle(3);
    chk("udf_early", tmr_udf, 0);
    idle(1);
    chk("udf_set", tmr_udf, 1);
    wr(5'h0C, 32'h0);
    rd_chk("udf_reload", 5'h00, 32'h5);

    // compare match and W1C collision
    wr(5'h10, 32'h7);
    wr(5'h08, 32'h10);
    wr(5'h00, 32'h0E);
    wr(5'h0C, 32'h1);
    idle(1);
    wr(5'h10, 32'h4);
    wr(5'h0C, 32'h0);
    rd_chk("cmf_survives_w1c", 5'h10, 32'h4);
    rd_chk("cmp_tcnt", 5'h00, 32'h13);
    wr(5'h10, 32'h4);
    rd_chk("cmf_cleared", 5'h10, 32'h0);

    // load is self-clearing; TCNT write beats a coincident tick
    wr(5'h04, 32'h33);
    wr(5'h0C, 32'h08);
    rd_chk("load_reads0", 5'h0C, 32'h0);
    rd_chk("load_tcnt", 5'h00, 32'h33);
    wr(5'h0C, 32'h21);
    idle(2);
    wr(5'h00, 32'hAA);
    wr(5'h0C, 32'h0);
    rd_chk("wr_beats_tick", 5'h00, 32'hAA);

    // illegal addresses
    apb(1, 5'h02, 32'h55, rd, err);
    chk("err_02", err, 1);
    apb(0, 5'h18, 0, rd, err);
    chk("err_18", err, 1);
    chk("err_18_prdata", rd, 0);
    rd_chk("err_no_change", 5'h00, 32'hAA);

    // randomized traffic
    for (int t = 0; t < 1500; t++) begin
      op = $urandom_range(0, 9);
      a  = 5'($urandom_range(0, 5) * 4);
      d  = $urandom;
      case (op)
        0, 1: idle($urandom_range(1, 3));
        2: begin
          case ($urandom_range(0, 2))
            0: d = $urandom_range(65532, 65535);
            1: d = $urandom_range(0, 3);
            default: d = $urandom;
          endcase
          wr(5'h00, d);
        end
        3: begin
          d = {25'd0, 3'($urandom_range(0, 2)), 1'($urandom_range(0, 9) == 0),
               3'($urandom_range(0, 7))};
          if ($urandom_range(0, 15) == 0) d[6:4] = 3'($urandom_range(0, 7));
          if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
          wr(5'h0C, d);
        end
        4: wr(5'h10, d);
        5: wr(5'h14, d);
        6: wr(($urandom_range(0, 1) != 0) ? 5'h04 : 5'h08, $urandom_range(0, 3) == 0 ? $urandom_range(0, 7) : d);
        7: begin
          a = 5'($urandom_range(0, 31));
          apb($urandom_range(0, 1) == 1, a, d, rd, err);
        end
        default: apb(0, a, 0, rd, err);
      endcase
    end

    // asynchronous reset mid-count
    wr(5'h0C, 32'h0);
    wr(5'h00, 32'h1234);
    wr(5'h08, 32'h1234);
    wr(5'h14, 32'h7);
    wr(5'h0C, 32'h1);
    idle(3);
    chk("pre_reset_irq", irq, 1);
    #2;
    preset = 1;
    model_reset();
    #1;
    chk("async_rst_irq", irq, 0);
    chk("async_rst_ovf", tmr_ovf, 0);
    chk("async_rst_udf", tmr_udf, 0);
    @(posedge pclk); #1;
    preset = 0;
    idle(10);
    rd_chk("post_rst_tcnt", 5'h00, 0);
    rd_chk("post_rst_tcr", 5'h0C, 0);
    rd_chk("post_rst_tier", 5'h14, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
